// File: rtl/adam_stream_skid_pkg.sv
// Shared constants for the ADAM stream skid buffer.
package adam_stream_skid_pkg;

    // Default payload width of an ADAM stream word.
    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

endpackage : adam_stream_skid_pkg

// File: rtl/adam_stream_skid.sv
// Two-entry skid buffer for a valid/ready stream. Every handshake output is a
// flop, so no combinational path crosses between the slv and mst sides.
module adam_stream_skid
    import adam_stream_skid_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] slv_data,
    input  logic                  slv_valid,
    output logic                  slv_ready,
    output logic [DATA_WIDTH-1:0] mst_data,
    output logic                  mst_valid,
    input  logic                  mst_ready
);

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    // Dedicated flop holding !skid_valid so slv_ready leaves a register directly.
    logic                  ready_q;

    logic in_fire_c;
    logic out_free_c;

    // Handshake qualifiers for the upcoming edge.
    always_comb begin
        in_fire_c  = slv_valid & ready_q;
        out_free_c = ~out_valid | mst_ready;
    end

    // Output and skid register update; the skid word always drains before new input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b1;
        end else if (out_free_c) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else if (in_fire_c) begin
                out_valid <= 1'b1;
                out_data  <= slv_data;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire_c) begin
            skid_valid <= 1'b1;
            skid_data  <= slv_data;
            ready_q    <= 1'b0;
        end
    end

    assign slv_ready = ready_q;
    assign mst_valid = out_valid;
    assign mst_data  = out_data;

endmodule : adam_stream_skid

// File: tb/tb_adam_stream_skid.sv
// Self-checking bench for adam_stream_skid with an in-order scoreboard.
module tb_adam_stream_skid;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] slv_data;
    logic          slv_valid;
    logic          slv_ready;
    logic [DW-1:0] mst_data;
    logic          mst_valid;
    logic          mst_ready;

    int total;
    int bad;
    int rx_count;
    logic [DW-1:0] sb_q[$];

    logic          hold_pending;
    logic [DW-1:0] hold_data;

    adam_stream_skid #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .slv_data (slv_data),
        .slv_valid(slv_valid),
        .slv_ready(slv_ready),
        .mst_data (mst_data),
        .mst_valid(mst_valid),
        .mst_ready(mst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            // Occupancy model: two stored words means the skid is full.
            total++;
            if (slv_ready !== (sb_q.size() < 2)) begin
                bad++;
                $display("FAIL sb_ready: got %b want %b (occupancy %0d)", slv_ready, sb_q.size() < 2, sb_q.size());
            end
            total++;
            if (mst_valid !== (sb_q.size() > 0)) begin
                bad++;
                $display("FAIL sb_valid: got %b want %b (occupancy %0d)", mst_valid, sb_q.size() > 0, sb_q.size());
            end
            if (hold_pending) begin
                total++;
                if (mst_valid !== 1'b1 || mst_data !== hold_data) begin
                    bad++;
                    $display("FAIL stall_stable: got v=%b d=%h want v=1 d=%h", mst_valid, mst_data, hold_data);
                end
            end
            hold_pending = mst_valid & ~mst_ready;
            hold_data    = mst_data;
            if (mst_valid && mst_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_pop: got %h want nothing (queue empty)", mst_data);
                end else begin
                    if (mst_data !== sb_q[0]) begin
                        bad++;
                        $display("FAIL sb_data: got %h want %h", mst_data, sb_q[0]);
                    end
                    void'(sb_q.pop_front());
                end
                rx_count++;
            end
            if (slv_valid && slv_ready) sb_q.push_back(slv_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        slv_data  = '0;
        slv_valid = 1'b0;
        mst_ready = 1'b0;
        repeat (3) cyc();
        total++;
        if (mst_valid !== 1'b0 || mst_data !== '0 || slv_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h r=%b want v=0 d=0 r=1", mst_valid, mst_data, slv_ready);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        mst_ready = 1'b1;
        slv_data  = 32'h0000_0000;
        slv_valid = 1'b1;
        cyc();
        slv_valid = 1'b0;
        slv_data  = 32'hdead_beef;
        total++;
        if (mst_valid !== 1'b1 || mst_data !== 32'h0) begin
            bad++;
            $display("FAIL basic_latency: got v=%b d=%h want v=1 d=0", mst_valid, mst_data);
        end
        cyc();
        total++;
        if (mst_valid !== 1'b0 || slv_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_empty: got v=%b r=%b want v=0 r=1", mst_valid, slv_ready);
        end
    endtask

    task automatic test_stall();
        mst_ready = 1'b0;
        slv_data  = 32'h0;
        slv_valid = 1'b1;
        cyc();
        total++;
        if (slv_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_first_ready: got %b want 1", slv_ready);
        end
        cyc();
        slv_valid = 1'b0;
        total++;
        if (slv_ready !== 1'b0 || mst_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_full: got r=%b v=%b want r=0 v=1", slv_ready, mst_valid);
        end
        mst_ready = 1'b1;
        cyc();
        total++;
        if (slv_ready !== 1'b1 || mst_valid !== 1'b1 || mst_data !== 32'h0) begin
            bad++;
            $display("FAIL stall_drain1: got r=%b v=%b d=%h want r=1 v=1 d=0", slv_ready, mst_valid, mst_data);
        end
        cyc();
        total++;
        if (mst_valid !== 1'b0 || slv_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_drain2: got v=%b r=%b want v=0 r=1", mst_valid, slv_ready);
        end
    endtask

    task automatic test_order();
        mst_ready = 1'b0;
        slv_valid = 1'b1;
        slv_data  = 32'h11;
        cyc();
        slv_data  = 32'h22;
        cyc();
        slv_data  = 32'h33;
        repeat (3) begin
            cyc();
            total++;
            if (slv_ready !== 1'b0 || mst_data !== 32'h11) begin
                bad++;
                $display("FAIL order_full: got r=%b d=%h want r=0 d=00000011", slv_ready, mst_data);
            end
        end
        mst_ready = 1'b1;
        cyc();
        total++;
        if (mst_data !== 32'h22 || mst_valid !== 1'b1) begin
            bad++;
            $display("FAIL order_second: got v=%b d=%h want v=1 d=00000022", mst_valid, mst_data);
        end
        cyc();
        slv_valid = 1'b0;
        total++;
        if (mst_data !== 32'h33 || mst_valid !== 1'b1) begin
            bad++;
            $display("FAIL order_third: got v=%b d=%h want v=1 d=00000033", mst_valid, mst_data);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        mst_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            slv_data  = DW'(i);
            slv_valid = 1'b1;
            total++;
            if (slv_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: word %0d got %b want 1", i, slv_ready);
            end
            cyc();
            total++;
            if (mst_valid !== 1'b1 || mst_data !== DW'(i)) begin
                bad++;
                $display("FAIL b2b_data: got v=%b d=%h want v=1 d=%h", mst_valid, mst_data, DW'(i));
            end
        end
        slv_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        mst_ready = 1'b0;
        slv_valid = 1'b1;
        slv_data  = 32'haaaa_0001;
        cyc();
        slv_data  = 32'haaaa_0002;
        cyc();
        slv_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        total++;
        if (mst_valid !== 1'b0 || slv_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got v=%b r=%b want v=0 r=1", mst_valid, slv_ready);
        end
        cyc();
        rst_n     = 1'b1;
        mst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (mst_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_stale: got v=%b d=%h want v=0", mst_valid, mst_data);
            end
        end
    endtask

    task automatic test_random();
        int sent;
        int cycles;
        int start_rx;
        bit acc;
        sent     = 0;
        cycles   = 0;
        start_rx = rx_count;
        while (sent < 1000 && cycles < 20000) begin
            mst_ready = ($urandom_range(0, 9) < 6);
            slv_valid = ($urandom_range(0, 9) < 7);
            slv_data  = $urandom;
            acc = slv_valid && slv_ready;
            cyc();
            if (acc) sent++;
            cycles++;
        end
        slv_valid = 1'b0;
        mst_ready = 1'b1;
        cycles = 0;
        while (sb_q.size() > 0 && cycles < 100) begin
            cyc();
            cycles++;
        end
        cyc();
        total++;
        if (sent != 1000 || rx_count - start_rx != 1000) begin
            bad++;
            $display("FAIL random_count: got sent=%0d received=%0d want 1000/1000", sent, rx_count - start_rx);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rx_count     = 0;
        hold_pending = 1'b0;
        hold_data    = '0;
        test_reset();
        test_basic();
        test_stall();
        test_order();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_adam_stream_skid
